// File: rtl/int_controller_pkg.sv
// int_controller_pkg
// Shared definitions for the platform interrupt controller:
//   - INT_CODE_WIDTH default (code = source index + 1, 0 = none)
//   - config register word addresses
//   - FSM state encoding
// Optional feature macro used by the controller: INT_CTRL_EDGE_EN
`ifndef INT_CODE_WIDTH
`define INT_CODE_WIDTH 5
`endif

package int_controller_pkg;

  localparam int CODE_W_DEF = `INT_CODE_WIDTH;

  localparam logic [5:0] PRIO_BASE  = 6'h00;
  localparam logic [5:0] EN_ADDR    = 6'h20;
  localparam logic [5:0] THR_ADDR   = 6'h21;
  localparam logic [5:0] PEND_ADDR  = 6'h22;
  localparam logic [5:0] CLAIM_ADDR = 6'h23;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_SERVICE
  } state_t;

endpackage

// File: rtl/int_controller_if.sv
// int_controller_if
// Bundles the peripheral request lines, the config bus and the CSR-file
// claim/complete handshake of the interrupt controller.
//   master : peripherals + core side (drives requests, config, claim/complete)
//   slave  : the controller (drives cfg_rdata, int_code, claim_code)
interface int_controller_if
  import int_controller_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int CODE_W  = CODE_W_DEF
);

  logic [NUM_SRC-1:0] src_irq;
  logic               cfg_we;
  logic [5:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic [31:0]        cfg_rdata;
  logic [CODE_W-1:0]  int_code;
  logic               claim;
  logic [CODE_W-1:0]  claim_code;
  logic               complete;
  logic [CODE_W-1:0]  complete_code;

  modport master (
    output src_irq, cfg_we, cfg_addr, cfg_wdata, claim, complete, complete_code,
    input  cfg_rdata, int_code, claim_code
  );

  modport slave (
    input  src_irq, cfg_we, cfg_addr, cfg_wdata, claim, complete, complete_code,
    output cfg_rdata, int_code, claim_code
  );

endinterface

// File: rtl/int_prio_sel.sv
// int_prio_sel
// Combinational max-priority selector over the eligible sources.
// Ports:
//   i_elig  : eligible vector, one bit per source
//   i_prio  : per-source priority
//   o_valid : at least one source is eligible
//   o_idx   : index of the winner (highest priority, lowest index on a tie)
module int_prio_sel #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int CODE_W  = 5
) (
  input  logic [NUM_SRC-1:0][PRIO_W-1:0] i_prio,
  input  logic [NUM_SRC-1:0]             i_elig,
  output logic                           o_valid,
  output logic [CODE_W-1:0]              o_idx
);

  logic [PRIO_W-1:0] w_best;

  // Scanning upward and replacing only on a strictly greater priority
  // leaves the lowest index in place when priorities tie.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_best  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_elig[i] && (!o_valid || (i_prio[i] > w_best))) begin
        o_valid = 1'b1;
        o_idx   = CODE_W'(i);
        w_best  = i_prio[i];
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// int_controller
// Platform interrupt arbiter: latches per-source requests, filters them by
// enable mask / priority / threshold, offers the winner code to the CSR file
// and sequences claim/complete so each request is serviced once.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : int_controller_if.slave (requests, config bus, claim/complete)
// Macro INT_CTRL_EDGE_EN: when defined the gateway latches on 0->1 edges of
// src_irq; otherwise it is level-sensitive.
module int_controller
  import int_controller_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int CODE_W  = CODE_W_DEF
) (
  input logic             clk,
  input logic             rst,
  int_controller_if.slave bus
);

  logic [NUM_SRC-1:0][PRIO_W-1:0] r_prio;
  logic [NUM_SRC-1:0]             r_en;
  logic [PRIO_W-1:0]              r_thr;
  logic [NUM_SRC-1:0]             r_pending;
  logic [CODE_W-1:0]              r_int_code;
  logic [CODE_W-1:0]              r_claim_code;
  state_t                         r_state;

  state_t                         w_state_nxt;
  logic [CODE_W-1:0]              w_int_code_nxt;
  logic [CODE_W-1:0]              w_claim_code_nxt;
  logic [NUM_SRC-1:0]             w_clr;
  logic [NUM_SRC-1:0]             w_set;
  logic [NUM_SRC-1:0]             w_elig;
  logic                           w_win_valid;
  logic [CODE_W-1:0]              w_win_idx;
  logic [CODE_W-1:0]              w_win_code;
  logic [31:0]                    w_rdata;
  logic                           w_unused_wdata;

  assign w_unused_wdata = &{1'b0, bus.cfg_wdata};

  // Config registers; pending and claim_code are read-only views.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= '0;
      r_en   <= '0;
      r_thr  <= '0;
    end else if (bus.cfg_we) begin
      if (bus.cfg_addr == EN_ADDR)  r_en  <= bus.cfg_wdata[NUM_SRC-1:0];
      if (bus.cfg_addr == THR_ADDR) r_thr <= bus.cfg_wdata[PRIO_W-1:0];
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.cfg_addr == PRIO_BASE + 6'(i)) r_prio[i] <= bus.cfg_wdata[PRIO_W-1:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.cfg_addr == EN_ADDR)         w_rdata = 32'(r_en);
    else if (bus.cfg_addr == THR_ADDR)   w_rdata = 32'(r_thr);
    else if (bus.cfg_addr == PEND_ADDR)  w_rdata = 32'(r_pending);
    else if (bus.cfg_addr == CLAIM_ADDR) w_rdata = 32'(r_claim_code);
    else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.cfg_addr == PRIO_BASE + 6'(i)) w_rdata = 32'(r_prio[i]);
      end
    end
  end

  assign bus.cfg_rdata = w_rdata;

`ifdef INT_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= '0;
    else     r_prev <= bus.src_irq;
  end

  // A rising edge seen while the source is in service is simply lost.
  always_comb begin
    w_set = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_set[i] = bus.src_irq[i] && !r_prev[i] && (r_claim_code != CODE_W'(i + 1));
    end
  end
`else
  always_comb begin
    w_set = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_set[i] = bus.src_irq[i] && (r_claim_code != CODE_W'(i + 1));
    end
  end
`endif

  // Clear beats set so a claim racing a new request leaves the bit low.
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending | w_set) & ~w_clr;
  end

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_elig[i] = r_pending[i] && r_en[i] && (r_prio[i] > r_thr);
    end
  end

  int_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W),
    .CODE_W  (CODE_W)
  ) u_prio_sel (
    .i_prio  (r_prio),
    .i_elig  (w_elig),
    .o_valid (w_win_valid),
    .o_idx   (w_win_idx)
  );

  assign w_win_code = w_win_idx + CODE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_int_code   <= '0;
      r_claim_code <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_int_code   <= w_int_code_nxt;
      r_claim_code <= w_claim_code_nxt;
    end
  end

  // In PEND the offered code is always nonzero, so a claim there always
  // maps onto exactly one pending bit to clear.
  always_comb begin
    w_state_nxt      = r_state;
    w_int_code_nxt   = r_int_code;
    w_claim_code_nxt = r_claim_code;
    w_clr            = '0;
    case (r_state)
      ST_IDLE: begin
        w_int_code_nxt = '0;
        if (w_win_valid) begin
          w_int_code_nxt = w_win_code;
          w_state_nxt    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (bus.claim) begin
          w_claim_code_nxt = r_int_code;
          w_int_code_nxt   = '0;
          w_state_nxt      = ST_SERVICE;
          for (int i = 0; i < NUM_SRC; i++) begin
            if (r_int_code == CODE_W'(i + 1)) w_clr[i] = 1'b1;
          end
        end else if (w_win_valid) begin
          w_int_code_nxt = w_win_code;
        end else begin
          w_int_code_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        w_int_code_nxt = '0;
        if (bus.complete && (bus.complete_code == r_claim_code)) begin
          w_claim_code_nxt = '0;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_int_code_nxt = '0;
      end
    endcase
  end

  assign bus.int_code   = r_int_code;
  assign bus.claim_code = r_claim_code;

endmodule
